echo_request_driver: RTL

Initiator end of the echo request/indication path. Issues a programmed sequence of echo requests into the responder's request method with ENA/RDY handshake, accepts returning echo indications, checks each against the value it sent, and reports completion through `done` and a one-cycle `stop_main_program` pulse. It is the hardware replacement for the software test driver and sits between the test harness and the echo responder.

---
 rtl/echo_pkg.sv | 14 +
 rtl/echo_expect_fifo.sv | 49 ++++
 rtl/echo_request_driver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/echo_pkg.sv
// Shared constants and state encoding for the echo request/indication path.
package echo_pkg;

    localparam int ECHO_WIDTH = 32;
    localparam int ECHO_SEED  = 22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/echo_expect_fifo.sv
// Ring buffer of expected echo values; supports push and pop in the same cycle,
// including when full, because the head is read before the slot is overwritten.
module echo_expect_fifo
    import echo_pkg::*;
#(
    parameter int WIDTH = ECHO_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/echo_request_driver.sv
// Echo initiator: issues SEED+k requests, checks returning indications, reports completion.
// Optional feature macro: ECHO_REQUEST_DRIVER_CHECK_EN (expected FIFO and comparison).
module echo_request_driver
    import echo_pkg::*;
#(
    parameter int WIDTH = ECHO_WIDTH,
    parameter int DEPTH = 4,
    parameter int SEED  = ECHO_SEED
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [15:0]      num_req,
    output logic             req_ENA,
    input  logic             req_RDY,
    output logic [WIDTH-1:0] req_v,
    input  logic             ind_ENA,
    output logic             ind_RDY,
    input  logic [WIDTH-1:0] ind_v,
    output logic             busy,
    output logic             done,
    output logic             stop_main_program,
    output logic             error,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] mismatch_got
);

    localparam int CW = $clog2(DEPTH) + 1;

    drv_state_t       r_state;
    drv_state_t       w_next_state;
    logic [15:0]      r_num_req;
    logic [15:0]      r_issued;
    logic             r_stop;
    logic [CW-1:0]    w_outstanding;
    logic             w_start_acc;
    logic             w_busy;
    logic             w_req_ena;
    logic             w_ind_rdy;
    logic             w_req_fire;
    logic             w_ind_fire;
    logic             w_last_req;
    logic [WIDTH-1:0] w_req_value;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
    // Built only from registered state so it never depends on req_RDY.
    assign w_req_ena   = (r_state == RUN) && (r_issued < r_num_req)
                         && (w_outstanding < CW'(DEPTH));
    assign w_ind_rdy   = w_busy && (w_outstanding != '0);
    assign w_req_fire  = w_req_ena && req_RDY;
    assign w_ind_fire  = ind_ENA && w_ind_rdy;
    assign w_last_req  = w_req_fire && ((r_issued + 16'd1) == r_num_req);
    assign w_req_value = WIDTH'(SEED) + WIDTH'(r_issued);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) w_next_state = (num_req == 16'd0) ? DONE : RUN;
            end
            RUN: begin
                if (w_last_req) w_next_state = DRAIN;
            end
            DRAIN: begin
                if ((w_outstanding == '0) || (w_ind_fire && (w_outstanding == CW'(1))))
                    w_next_state = DONE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_num_req <= '0;
            r_issued  <= '0;
            r_stop    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_stop  <= (w_next_state == DONE) && ((r_state != DONE) || w_start_acc);
            if (w_start_acc) begin
                r_num_req <= num_req;
                r_issued  <= '0;
            end else if (w_req_fire) begin
                r_issued  <= r_issued + 16'd1;
            end
        end
    end

`ifdef ECHO_REQUEST_DRIVER_CHECK_EN
    logic [WIDTH-1:0] w_head;
    logic             w_mismatch;
    logic             r_error;
    logic [15:0]      r_err_count;
    logic [WIDTH-1:0] r_mismatch_got;

    echo_expect_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_expect_fifo (
        .clk         (CLK),
        .rst_n       (nRST),
        .i_push      (w_req_fire),
        .i_push_data (w_req_value),
        .i_pop       (w_ind_fire),
        .o_head      (w_head),
        .o_count     (w_outstanding)
    );

    assign w_mismatch = w_ind_fire && (w_head != ind_v);

    // Only the first mismatching payload of a run is captured.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_error        <= 1'b0;
            r_err_count    <= '0;
            r_mismatch_got <= '0;
        end else if (w_start_acc) begin
            r_error        <= 1'b0;
            r_err_count    <= '0;
            r_mismatch_got <= '0;
        end else if (w_mismatch) begin
            r_error <= 1'b1;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (!r_error) r_mismatch_got <= ind_v;
        end
    end

    assign error        = r_error;
    assign err_count    = r_err_count;
    assign mismatch_got = r_mismatch_got;
`else
    logic [CW-1:0] r_occ;
    logic          w_unused_ind;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_occ <= '0;
        end else begin
            case ({w_req_fire, w_ind_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign w_outstanding = r_occ;
    assign w_unused_ind  = ^ind_v;
    assign error         = 1'b0;
    assign err_count     = '0;
    assign mismatch_got  = '0;
`endif

    assign req_ENA           = w_req_ena;
    assign req_v             = w_req_ena ? w_req_value : '0;
    assign ind_RDY           = w_ind_rdy;
    assign busy              = w_busy;
    assign done              = (r_state == DONE);
    assign stop_main_program = r_stop;

endmodule
